// File: rtl/fifo_param.sv
// Parametrised synchronous FIFO for PCM samples: occupancy count, almost-full/
// almost-empty thresholds, sticky overflow/underflow flags, standard or FWFT read.
module fifo_param #(
  parameter int unsigned DATA_WIDTH = 8,
  parameter int unsigned ADDR_WIDTH = 4,
  parameter int unsigned AF_LEVEL   = 12,
  parameter int unsigned AE_LEVEL   = 4,
  parameter int unsigned FWFT       = 0
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  wr,
  input  logic [DATA_WIDTH-1:0] data_in,
  input  logic                  rd,
  output logic [DATA_WIDTH-1:0] data_out,
  output logic                  full,
  output logic                  empty,
  output logic                  almost_full,
  output logic                  almost_empty,
  output logic [ADDR_WIDTH:0]   count,
  output logic                  overflow,
  output logic                  underflow,
  input  logic                  clr_err
);

  localparam int unsigned DEPTH = 2 ** ADDR_WIDTH;
  localparam int unsigned CW    = ADDR_WIDTH + 1;

  logic [DATA_WIDTH-1:0] mem [DEPTH];
  logic [ADDR_WIDTH-1:0] wr_ptr;
  logic [ADDR_WIDTH-1:0] rd_ptr;
  logic [CW-1:0]         count_q;
  logic                  overflow_q;
  logic                  underflow_q;
  logic                  rd_ok;
  logic                  wr_ok;

  // Status flags decode the registered occupancy directly.
  assign count        = count_q;
  assign empty        = (count_q == '0);
  assign full         = (count_q == CW'(DEPTH));
  assign almost_full  = (count_q >= CW'(AF_LEVEL));
  assign almost_empty = (count_q <= CW'(AE_LEVEL));
  assign overflow     = overflow_q;
  assign underflow    = underflow_q;

  // A write into a full FIFO is only accepted when a read frees a slot.
  assign rd_ok = rd & ~empty;
  assign wr_ok = wr & (~full | rd_ok);

  // Storage is deliberately left out of reset.
  always_ff @(posedge clk) begin
    if (wr_ok) begin
      mem[wr_ptr] <= data_in;
    end
  end

  // Pointers wrap naturally at the power-of-two depth; count tracks net change.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      wr_ptr  <= '0;
      rd_ptr  <= '0;
      count_q <= '0;
    end else begin
      if (wr_ok) begin
        wr_ptr <= wr_ptr + ADDR_WIDTH'(1);
      end
      if (rd_ok) begin
        rd_ptr <= rd_ptr + ADDR_WIDTH'(1);
      end
      if (wr_ok && !rd_ok) begin
        count_q <= count_q + CW'(1);
      end else if (rd_ok && !wr_ok) begin
        count_q <= count_q - CW'(1);
      end
    end
  end

  // Sticky error flags; a new event in the clearing cycle keeps the flag set.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      overflow_q  <= 1'b0;
      underflow_q <= 1'b0;
    end else begin
      overflow_q  <= (wr & ~wr_ok) | (overflow_q & ~clr_err);
      underflow_q <= (rd & empty)  | (underflow_q & ~clr_err);
    end
  end

  if (FWFT != 0) begin : g_fwft
    // Head word is presented whenever the FIFO holds data; zero while empty.
    assign data_out = empty ? '0 : mem[rd_ptr];
  end else begin : g_std
    logic [DATA_WIDTH-1:0] dout_q;

    // Registered read: head word captured on the accepting read edge.
    always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
        dout_q <= '0;
      end else if (rd_ok) begin
        dout_q <= mem[rd_ptr];
      end
    end

    assign data_out = dout_q;
  end

endmodule
